spi_byte_stream: RTL and testbench
==================================

// Module: spi_byte_stream
// PURPOSE
//  Byte-stream front end for the byte-level SPI master engine. Buffers bytes from the
//  processor bus in a TX FIFO and launches one engine transfer per byte. Captures each
//  received byte into an RX FIFO. Both bus-side interfaces are valid/ready, so software
//  never polls the engine's busy flag.
// PARAMETERS
//  FIFO_DEPTH  4  entries per TX/RX FIFO; power of 2, >=2
//  LVL_W       $clog2(FIFO_DEPTH)+1  derived width of the level outputs (localparam)
// PORTS
//  clk                input   1      system clock, rising edge
//  rst                input   1      asynchronous, active-high reset
//  tx_data            input   8      byte to transmit
//  tx_valid           input   1      tx_data valid
//  tx_ready           output  1      TX FIFO not full
//  rx_data            output  8      received byte, head of RX FIFO
//  rx_valid           output  1      RX FIFO not empty
//  rx_ready           input   1      consumer takes rx_data
//  flush              input   1      sync clear of both FIFOs and the FSM (see rules)
//  spi_data           output  8      to engine data
//  spi_load_data      output  1      to engine load_data; 1-cycle pulse
//  spi_busy           input   1      from engine busy; goes high in the same cycle as load
//  spi_received_data  input   8      from engine received_data; valid once busy falls
//  tx_level           output  LVL_W  TX FIFO occupancy
//  rx_level           output  LVL_W  RX FIFO occupancy
//  idle               output  1      FSM in IDLE and TX FIFO empty
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE; both FIFOs empty.
//   Output values in reset: tx_ready=1, rx_valid=0, spi_load_data=0, spi_data=0,
//   levels=0, idle=1, rx_data=0.
//  FIFO handshake:
//   - Push on tx_valid&tx_ready. Pop on rx_valid&rx_ready.
//   - Push and pop in the same cycle on either FIFO are both honoured; the level is unchanged.
//   - Pointers wrap modulo FIFO_DEPTH. Full is level==FIFO_DEPTH.
//   - rx_data is the registered head of the RX FIFO; it is a don't-care when empty.
//  FSM states: IDLE, LOAD, WAIT, CAPTURE.
//   - IDLE -> LOAD: TX not empty AND rx_level+inflight < FIFO_DEPTH. This reserves RX
//     space, so an RX byte is never dropped.
//   - LOAD (1 cycle): spi_load_data=1, spi_data=TX head, pop TX. Go to WAIT.
//   - WAIT: stay while spi_busy=1. On spi_busy=0, go to CAPTURE.
//   - CAPTURE (1 cycle): push spi_received_data into RX. Go to IDLE.
//   - spi_load_data is registered, decoded from state==LOAD. spi_data holds its value outside LOAD.
//  Latency:
//   - Push into empty TX at edge N: LOAD in cycle N+2.
//   - Busy falling seen in cycle M: byte is in RX, rx_valid=1, from cycle M+2.
//   - Back-to-back overhead: 3 clk between engine transfers (CAPTURE, IDLE, LOAD).
//  Boundaries:
//   - TX full: tx_ready=0. A push in a cycle where LOAD pops is still refused (ready is
//     decoded from level only).
//   - RX full: the transfer in flight still completes into its reserved slot. No new
//     LOAD until the consumer pops.
//   - flush in IDLE/CAPTURE/LOAD: both FIFOs clear next cycle, FSM->IDLE. A LOAD-cycle
//     pulse already issued is not retracted.
//   - flush in WAIT: TX clears; FSM finishes WAIT, discards the captured byte, then ->IDLE.
//   - rst mid-transfer resets this block only. The engine shares rst, so both restart clean.
//   - spi_busy high while IDLE (engine misuse): no LOAD is issued until it is low.
// STRUCTURE
//  Package spi_pkg:
//   - typedef enum logic [1:0] spi_strm_state_t {IDLE, LOAD, WAIT, CAPTURE}
//   - localparam SPI_BYTE_W = 8
//  Sub-module sync_fifo #(WIDTH, DEPTH), instantiated twice (TX, RX):
//   - ports: push, pop, din, dout, full, empty, level, clr
//   - async reset, registered dout
//  Top level: FSM, inflight bit, reservation compare, idle decode.
// TESTING
//  1 Single byte: push 0xA5; engine model returns 0x3C -> exactly one spi_load_data pulse
//    with spi_data=0xA5 in cycle N+2; rx_data=0x3C, rx_valid=1, rx_level=1.
//  2 Burst: push 0x01..0x06 with FIFO_DEPTH=4 -> tx_ready low after 4 stored.
//    Loads occur in order 01..06; RX holds echoes in order; no load while busy.
//  3 RX backpressure: rx_ready=0, send 6 bytes -> exactly 4 transfers, then stall.
//    rx_level=4, tx_level=2. Pop one -> exactly one more transfer follows.
//  4 Simultaneous push/pop: TX at level 2, push coinciding with LOAD pop -> tx_level stays 2.
//    RX push in CAPTURE with rx pop -> rx_level unchanged.
//  5 flush during WAIT with 3 bytes queued -> engine transfer completes.
//    Its byte is not in RX; tx_level=0, rx_level=0; idle=1 within 2 cycles after busy falls.
//  6 Async rst asserted mid-WAIT (between clock edges) -> outputs reach reset values
//    immediately. After release, push 0x77 -> normal single-byte result.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI byte-stream front end.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    CAPTURE
  } spi_strm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output and a synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_dout;

  logic             w_doPush;
  logic             w_doPop;
  logic [PTR_W-1:0] w_nextRd;

  assign o_full   = (r_level == LVL_W'(DEPTH));
  assign o_empty  = (r_level == '0);
  assign o_level  = r_level;
  assign o_dout   = r_dout;
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign w_nextRd = w_doPop ? r_rdPtr + PTR_W'(1) : r_rdPtr;

  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_din;
  end

  // A byte written into a slot that becomes the head this cycle bypasses the array.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_dout  <= '0;
    end else if (i_clr) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_dout  <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      r_rdPtr <= w_nextRd;
      if (w_doPush && !w_doPop)      r_level <= r_level + LVL_W'(1);
      else if (!w_doPush && w_doPop) r_level <= r_level - LVL_W'(1);
      r_dout <= (w_doPush && (w_nextRd == r_wrPtr)) ? i_din : r_mem[w_nextRd];
    end
  end

endmodule

// File: rtl/spi_byte_stream.sv
// Valid/ready byte-stream front end: TX FIFO feeds one engine transfer per byte,
// received bytes land in an RX FIFO whose slot is reserved before each load.
module spi_byte_stream
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [SPI_BYTE_W-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [SPI_BYTE_W-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  input  logic                  i_flush,
  output logic [SPI_BYTE_W-1:0] o_spi_data,
  output logic                  o_spi_load_data,
  input  logic                  i_spi_busy,
  input  logic [SPI_BYTE_W-1:0] i_spi_received_data,
  output logic [LVL_W-1:0]      o_tx_level,
  output logic [LVL_W-1:0]      o_rx_level,
  output logic                  o_idle
);

  spi_strm_state_t r_state;
  spi_strm_state_t w_nextState;

  logic                  r_inflight;
  logic                  r_discard;
  logic                  r_loadData;
  logic [SPI_BYTE_W-1:0] r_spiData;

  logic                  w_txFull;
  logic                  w_txEmpty;
  logic                  w_rxFull;
  logic                  w_rxEmpty;
  logic [SPI_BYTE_W-1:0] w_txHead;
  logic                  w_txPop;
  logic                  w_rxPush;
  logic                  w_rxPop;
  logic [LVL_W:0]        w_rxCommit;
  logic                  w_rxRoom;

  assign w_txPop    = (r_state == LOAD);
  assign w_rxPush   = (r_state == CAPTURE) && !r_discard;
  assign w_rxPop    = o_rx_valid & i_rx_ready;
  assign w_rxCommit = {1'b0, o_rx_level} + {{LVL_W{1'b0}}, r_inflight};
  assign w_rxRoom   = (w_rxCommit < (LVL_W + 1)'(FIFO_DEPTH));

  assign o_tx_ready      = ~w_txFull;
  assign o_rx_valid      = ~w_rxEmpty;
  assign o_spi_data      = r_spiData;
  assign o_spi_load_data = r_loadData;
  assign o_idle          = (r_state == IDLE) && w_txEmpty;

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_txFifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_flush),
    .i_push  (i_tx_valid & o_tx_ready),
    .i_pop   (w_txPop),
    .i_din   (i_tx_data),
    .o_dout  (w_txHead),
    .o_full  (w_txFull),
    .o_empty (w_txEmpty),
    .o_level (o_tx_level)
  );

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_rxFifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_flush),
    .i_push  (w_rxPush),
    .i_pop   (w_rxPop),
    .i_din   (i_spi_received_data),
    .o_dout  (o_rx_data),
    .o_full  (w_rxFull),
    .o_empty (w_rxEmpty),
    .o_level (o_rx_level)
  );

  // A load is only started once an RX slot is guaranteed and the engine is quiet.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!i_flush && !w_txEmpty && w_rxRoom && !i_spi_busy) w_nextState = LOAD;
      LOAD:    w_nextState = i_flush ? IDLE : WAIT;
      WAIT:    if (!i_spi_busy) w_nextState = CAPTURE;
      CAPTURE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
      r_loadData <= 1'b0;
      r_spiData  <= '0;
    end else begin
      r_state    <= w_nextState;
      r_inflight <= (w_nextState != IDLE);
      r_loadData <= (r_state == LOAD);
      if (r_state == LOAD) r_spiData <= w_txHead;
      if (r_state == WAIT && i_flush) r_discard <= 1'b1;
      else if (r_state == CAPTURE)    r_discard <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_byte_stream.sv
// Directed bench for spi_byte_stream with a small engine model that returns data ^ 0x99.
module tb_spi_byte_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic       flush;
  logic [7:0] spiData;
  logic       spiLoad;
  logic       spiBusy;
  logic [7:0] spiRx;
  logic [2:0] txLevel;
  logic [2:0] rxLevel;
  logic       idle;
  logic       forceBusy;

  int assertCount = 0;
  int failCount   = 0;

  logic [2:0] engCnt;
  logic [7:0] engRx;
  int         loadCount = 0;
  int         loadWhileBusy = 0;
  logic [7:0] loadLog [256];
  int         rxCount = 0;
  logic [7:0] rxLog [256];

  typedef struct {
    logic [7:0] txByte;
    logic [7:0] expRx;
  } vec_t;

  vec_t vecs [5];

  spi_byte_stream #(.FIFO_DEPTH(4)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_tx_data           (txData),
    .i_tx_valid          (txValid),
    .o_tx_ready          (txReady),
    .o_rx_data           (rxData),
    .o_rx_valid          (rxValid),
    .i_rx_ready          (rxReady),
    .i_flush             (flush),
    .o_spi_data          (spiData),
    .o_spi_load_data     (spiLoad),
    .i_spi_busy          (spiBusy),
    .i_spi_received_data (spiRx),
    .o_tx_level          (txLevel),
    .o_rx_level          (rxLevel),
    .o_idle              (idle)
  );

  always #5 clk = ~clk;

  // Engine model: busy rises with the load pulse and stays high four more cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      engCnt <= '0;
      engRx  <= '0;
    end else if (spiLoad) begin
      engCnt <= 3'd4;
      engRx  <= spiData ^ 8'h99;
    end else if (engCnt != 0) begin
      engCnt <= engCnt - 3'd1;
    end
  end

  assign spiBusy = spiLoad | (engCnt != 0) | forceBusy;
  assign spiRx   = engRx;

  always @(posedge clk) begin
    if (!rst && spiLoad) begin
      if (engCnt != 0) loadWhileBusy++;
      loadLog[loadCount[7:0]] = spiData;
      loadCount++;
    end
    if (!rst && rxValid && rxReady) begin
      rxLog[rxCount[7:0]] = rxData;
      rxCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    txData  = b;
    txValid = 1'b1;
    while (!txReady && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    txValid = 1'b0;
    checkOutput("push timeout", (n < 300), 1);
  endtask

  task automatic waitRxValid(input string name);
    int n = 0;
    while (!rxValid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, rxValid, 1);
  endtask

  task automatic waitBusyLow();
    int n = 0;
    while (spiBusy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("busy fall timeout", spiBusy, 0);
  endtask

  task automatic popOne();
    rxReady = 1'b1;
    @(posedge clk); #1;
    rxReady = 1'b0;
  endtask

  task automatic drainAll();
    int n = 0;
    rxReady = 1'b1;
    while (!(idle && !rxValid && !spiBusy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    rxReady = 1'b0;
    checkOutput("drain to idle", idle, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " tx_ready"}, txReady, 1);
    checkOutput({tag, " rx_valid"}, rxValid, 0);
    checkOutput({tag, " load"}, spiLoad, 0);
    checkOutput({tag, " spi_data"}, spiData, 0);
    checkOutput({tag, " tx_level"}, txLevel, 0);
    checkOutput({tag, " rx_level"}, rxLevel, 0);
    checkOutput({tag, " idle"}, idle, 1);
    checkOutput({tag, " rx_data"}, rxData, 0);
  endtask

  initial begin
    int base;
    int rbase;
    logic [7:0] burstExp [6];

    vecs[0] = '{txByte: 8'h00, expRx: 8'h99};
    vecs[1] = '{txByte: 8'hFF, expRx: 8'h66};
    vecs[2] = '{txByte: 8'h5A, expRx: 8'hC3};
    vecs[3] = '{txByte: 8'h77, expRx: 8'hEE};
    vecs[4] = '{txByte: 8'h04, expRx: 8'h9D};
    burstExp = '{8'h98, 8'h9B, 8'h9A, 8'h9D, 8'h9C, 8'h9F};

    rst = 1'b1; txData = '0; txValid = 1'b0; rxReady = 1'b0; flush = 1'b0; forceBusy = 1'b0;
    #2;
    checkResetValues("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single byte with latency");
    base = loadCount;
    applyStimulus(8'hA5);
    @(posedge clk); #1;
    checkOutput("t1 load at N+1", spiLoad, 0);
    @(posedge clk); #1;
    checkOutput("t1 load at N+2", spiLoad, 1);
    checkOutput("t1 spi_data", spiData, 8'hA5);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t1 rx_valid at M+1", rxValid, 0);
    @(posedge clk); #1;
    checkOutput("t1 rx_valid at M+2", rxValid, 1);
    checkOutput("t1 rx_data", rxData, 8'h3C);
    checkOutput("t1 rx_level", rxLevel, 1);
    checkOutput("t1 load count", loadCount - base, 1);
    popOne();

    $display("[TB] table of single-byte transfers");
    for (int i = 0; i < 5; i++) begin
      base = loadCount;
      applyStimulus(vecs[i].txByte);
      waitRxValid("vec rx_valid");
      checkOutput("vec rx_data", rxData, vecs[i].expRx);
      checkOutput("vec spi_data", loadLog[base[7:0]], vecs[i].txByte);
      popOne();
    end

    $display("[TB] burst of six");
    base  = loadCount;
    rbase = rxCount;
    rxReady = 1'b1;
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
    checkOutput("t2 tx_ready when full", txReady, 0);
    checkOutput("t2 tx_level when full", txLevel, 4);
    applyStimulus(8'h06);
    drainAll();
    checkOutput("t2 load count", loadCount - base, 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t2 load order", loadLog[8'(base + i)], 8'(i + 1));
      checkOutput("t2 rx order", rxLog[8'(rbase + i)], burstExp[i]);
    end

    $display("[TB] rx backpressure");
    base = loadCount;
    for (int i = 0; i < 6; i++) applyStimulus(8'h20 + 8'(i));
    repeat (60) @(posedge clk);
    #1;
    checkOutput("t3 loads before pop", loadCount - base, 4);
    checkOutput("t3 rx_level full", rxLevel, 4);
    checkOutput("t3 tx_level stalled", txLevel, 2);
    popOne();
    repeat (60) @(posedge clk);
    #1;
    checkOutput("t3 loads after pop", loadCount - base, 5);
    checkOutput("t3 rx_level after pop", rxLevel, 4);
    checkOutput("t3 tx_level after pop", txLevel, 1);
    drainAll();

    $display("[TB] simultaneous push/pop");
    base = loadCount;
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h30);
    checkOutput("t4 tx_level push+pop", txLevel, 2);
    begin
      int n = 0;
      while (loadCount - base < 2 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    checkOutput("t4 rx_level before", rxLevel, 1);
    waitBusyLow();
    @(posedge clk); #1;
    rxReady = 1'b1;
    @(posedge clk); #1;
    rxReady = 1'b0;
    checkOutput("t4 rx_level push+pop", rxLevel, 1);
    checkOutput("t4 rx_data head", rxData, 8'hB9);
    drainAll();

    $display("[TB] flush during wait");
    base = loadCount;
    applyStimulus(8'hC1);
    applyStimulus(8'hC2);
    applyStimulus(8'hC3);
    applyStimulus(8'hC4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("t5 tx_level after flush", txLevel, 0);
    waitBusyLow();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5 idle", idle, 1);
    checkOutput("t5 rx_level", rxLevel, 0);
    checkOutput("t5 rx_valid", rxValid, 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t5 load count", loadCount - base, 1);
    checkOutput("t5 rx_valid later", rxValid, 0);

    $display("[TB] busy held while idle");
    base = loadCount;
    forceBusy = 1'b1;
    applyStimulus(8'h42);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("busy idle no load", loadCount - base, 0);
    checkOutput("busy idle tx_level", txLevel, 1);
    forceBusy = 1'b0;
    waitRxValid("busy idle rx_valid");
    checkOutput("busy idle rx_data", rxData, 8'hDB);
    popOne();

    $display("[TB] async reset mid-wait");
    applyStimulus(8'h12);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkResetValues("t6 async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    base = loadCount;
    applyStimulus(8'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("t6 load at N+2", spiLoad, 1);
    checkOutput("t6 spi_data", spiData, 8'h77);
    waitRxValid("t6 rx_valid");
    checkOutput("t6 rx_data", rxData, 8'hEE);
    checkOutput("t6 rx_level", rxLevel, 1);
    checkOutput("t6 load count", loadCount - base, 1);

    checkOutput("load while busy", loadWhileBusy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
